cache_mem_arbiter: RTL and testbench

Shares one external cache-line memory port between the I-cache refill path and the D-cache refill/write-back path, so the Aquila SoC can use a single memory controller master. It sits between the I-cache/D-cache memory-side ports (D-side after the atomic unit) and the DRAM-facing master interface. It also sequences each transfer: capture the request, issue one strobe, wait for completion, return the line.

---
 rtl/cache_arb_pkg.sv | 12 +
 rtl/rr_arb2.sv | 39 +++
 rtl/cache_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared encodings for the cache/memory arbiter: FSM state codes and owner codes.
package cache_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester grant logic (I-side vs D-side). Round-robin by default;
// fixed D-priority when ARB_DCACHE_PRIORITY_EN is defined.
module rr_arb2
    import cache_arb_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_en,
    output logic o_gnt_valid,
    output logic o_gnt_owner
);

    assign o_gnt_valid = i_en & (i_req_i | i_req_d);

`ifdef ARB_DCACHE_PRIORITY_EN
    assign o_gnt_owner = i_req_d ? OWN_D : OWN_I;
`else
    logic r_last_grant;

    // On a tie, grant whoever did not win last time.
    always_comb begin
        o_gnt_owner = OWN_I;
        if (i_req_i && i_req_d)
            o_gnt_owner = (r_last_grant == OWN_I) ? OWN_D : OWN_I;
        else if (i_req_d)
            o_gnt_owner = OWN_D;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_last_grant <= OWN_I;
        else if (o_gnt_valid)
            r_last_grant <= o_gnt_owner;
    end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one cache-line memory port between I-cache refill and D-cache refill/write-back.
// Optional macro ARB_DCACHE_PRIORITY_EN selects fixed D-priority instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a pending request or strobe; latches the winner's request
// ISSUE | m_strobe_o high for one cycle
// WAIT  | waiting for m_done_i
// RESP  | owner's done_o pulse with the registered line
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CLSIZE = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_strobe_i,
    input  logic [XLEN-1:0]   i_addr_i,
    output logic              i_done_o,
    output logic [CLSIZE-1:0] i_data_o,
    input  logic              d_strobe_i,
    input  logic [XLEN-1:0]   d_addr_i,
    input  logic              d_rw_i,
    input  logic [CLSIZE-1:0] d_data_i,
    output logic              d_done_o,
    output logic [CLSIZE-1:0] d_data_o,
    output logic              m_strobe_o,
    output logic [XLEN-1:0]   m_addr_o,
    output logic              m_rw_o,
    output logic [CLSIZE-1:0] m_data_o,
    input  logic              m_done_i,
    input  logic [CLSIZE-1:0] m_data_i
);

    logic [1:0]        r_state;
    logic              r_i_pend;
    logic              r_d_pend;
    logic              r_owner;
    logic [XLEN-1:0]   r_addr;
    logic              r_rw;
    logic [CLSIZE-1:0] r_wdata;
    logic [CLSIZE-1:0] r_rdata;

    logic w_req_i;
    logic w_req_d;
    logic w_gnt_valid;
    logic w_gnt_owner;
    logic w_gnt_i;
    logic w_gnt_d;

    // Live strobes are OR'd in so a request is accepted the cycle it appears.
    assign w_req_i = r_i_pend | i_strobe_i;
    assign w_req_d = r_d_pend | d_strobe_i;

    rr_arb2 u_arb (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_req_i     (w_req_i),
        .i_req_d     (w_req_d),
        .i_en        (r_state == IDLE),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_owner (w_gnt_owner)
    );

    assign w_gnt_i = w_gnt_valid & (w_gnt_owner == OWN_I);
    assign w_gnt_d = w_gnt_valid & (w_gnt_owner == OWN_D);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_i_pend <= 1'b0;
            r_d_pend <= 1'b0;
            r_owner  <= OWN_I;
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_i_pend <= w_req_i & ~w_gnt_i;
            r_d_pend <= w_req_d & ~w_gnt_d;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner <= w_gnt_owner;
                        if (w_gnt_owner == OWN_D) begin
                            r_addr  <= d_addr_i;
                            r_rw    <= d_rw_i;
                            r_wdata <= d_rw_i ? d_data_i : '0;
                        end else begin
                            r_addr  <= i_addr_i;
                            r_rw    <= 1'b0;
                            r_wdata <= '0;
                        end
                        r_state <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (m_done_i) begin
                        r_rdata <= r_rw ? '0 : m_data_i;
                        r_state <= RESP;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_strobe_o = (r_state == ISSUE);
    assign m_addr_o   = r_addr;
    assign m_rw_o     = r_rw;
    assign m_data_o   = r_wdata;

    assign i_done_o = (r_state == RESP) && (r_owner == OWN_I);
    assign d_done_o = (r_state == RESP) && (r_owner == OWN_D);
    assign i_data_o = i_done_o ? r_rdata : '0;
    assign d_data_o = d_done_o ? r_rdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus queues expected memory requests
// and done responses; a negedge monitor pops and compares as the DUT presents them.
module tb_cache_mem_arbiter;

    localparam int XLEN   = 32;
    localparam int CLSIZE = 256;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              i_strobe_i;
    logic [XLEN-1:0]   i_addr_i;
    logic              i_done_o;
    logic [CLSIZE-1:0] i_data_o;
    logic              d_strobe_i;
    logic [XLEN-1:0]   d_addr_i;
    logic              d_rw_i;
    logic [CLSIZE-1:0] d_data_i;
    logic              d_done_o;
    logic [CLSIZE-1:0] d_data_o;
    logic              m_strobe_o;
    logic [XLEN-1:0]   m_addr_o;
    logic              m_rw_o;
    logic [CLSIZE-1:0] m_data_o;
    logic              m_done_i;
    logic [CLSIZE-1:0] m_data_i;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .i_strobe_i (i_strobe_i),
        .i_addr_i   (i_addr_i),
        .i_done_o   (i_done_o),
        .i_data_o   (i_data_o),
        .d_strobe_i (d_strobe_i),
        .d_addr_i   (d_addr_i),
        .d_rw_i     (d_rw_i),
        .d_data_i   (d_data_i),
        .d_done_o   (d_done_o),
        .d_data_o   (d_data_o),
        .m_strobe_o (m_strobe_o),
        .m_addr_o   (m_addr_o),
        .m_rw_o     (m_rw_o),
        .m_data_o   (m_data_o),
        .m_done_i   (m_done_i),
        .m_data_i   (m_data_i)
    );

    typedef struct {
        logic [XLEN-1:0]   addr;
        logic              rw;
        logic [CLSIZE-1:0] data;
    } mreq_t;

    typedef struct {
        logic              own;
        logic [CLSIZE-1:0] data;
    } dresp_t;

    mreq_t             m_q[$];
    dresp_t            d_q[$];
    logic [CLSIZE-1:0] mem_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int lat = 1;
    int rl;

    mreq_t  cur;
    mreq_t  me;
    dresp_t de;
    logic   inflight = 1'b0;
    logic   stable = 1'b1;
    int     strobe_cyc = 0;
    int     cur_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: answers each strobe after 'lat' cycles with the next queued line.
    initial begin
        m_done_i = 1'b0;
        m_data_i = '0;
        forever begin
            @(negedge clk);
            if (m_strobe_o && !rst_i) begin
                rl = lat;
                repeat (rl) @(negedge clk);
                #1;
                m_done_i = 1'b1;
                m_data_i = (mem_q.size() != 0) ? mem_q.pop_front() : '0;
                @(negedge clk);
                #1;
                m_done_i = 1'b0;
                m_data_i = '0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_i) begin
            inflight = 1'b0;
        end else begin
            if (m_strobe_o) begin
                total++;
                if (m_q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_unexpected got addr=%h rw=%0b want none", m_addr_o, m_rw_o);
                end else begin
                    me = m_q.pop_front();
                    if (m_addr_o !== me.addr || m_rw_o !== me.rw || m_data_o !== me.data) begin
                        bad++;
                        $display("FAIL strobe_req got addr=%h rw=%0b data=%h want addr=%h rw=%0b data=%h",
                                 m_addr_o, m_rw_o, m_data_o, me.addr, me.rw, me.data);
                    end
                    cur        = me;
                    inflight   = 1'b1;
                    stable     = 1'b1;
                    strobe_cyc = cyc;
                    cur_lat    = lat;
                end
            end else if (inflight && (m_addr_o !== cur.addr || m_rw_o !== cur.rw || m_data_o !== cur.data)) begin
                stable = 1'b0;
            end
            if (i_done_o || d_done_o) begin
                done_cnt++;
                total++;
                if (d_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected got i_done=%0b d_done=%0b want none", i_done_o, d_done_o);
                end else begin
                    de = d_q.pop_front();
                    if (i_done_o !== !de.own || d_done_o !== de.own ||
                        i_data_o !== (de.own ? '0 : de.data) || d_data_o !== (de.own ? de.data : '0)) begin
                        bad++;
                        $display("FAIL done_resp got i_done=%0b d_done=%0b idata=%h ddata=%h want own=%0b data=%h",
                                 i_done_o, d_done_o, i_data_o, d_data_o, de.own, de.data);
                    end
                    total++;
                    if (cyc != strobe_cyc + cur_lat + 1) begin
                        bad++;
                        $display("FAIL done_timing got cycle=%0d want cycle=%0d", cyc, strobe_cyc + cur_lat + 1);
                    end
                    total++;
                    if (stable !== 1'b1) begin
                        bad++;
                        $display("FAIL req_stable got stable=%0b want 1", stable);
                    end
                end
                inflight = 1'b0;
            end
        end
    end

    task automatic exp_req(input logic own, input logic [XLEN-1:0] addr, input logic rw,
                           input logic [CLSIZE-1:0] wdata, input logic [CLSIZE-1:0] mline);
        mreq_t  m;
        dresp_t d;
        m.addr = addr;
        m.rw   = rw;
        m.data = rw ? wdata : '0;
        m_q.push_back(m);
        d.own  = own;
        d.data = rw ? '0 : mline;
        d_q.push_back(d);
        mem_q.push_back(mline);
    endtask

    task automatic check_zero(input string nm);
        logic [1+CLSIZE+1+CLSIZE+1+XLEN+1+CLSIZE-1:0] v;
        v = {i_done_o, i_data_o, d_done_o, d_data_o, m_strobe_o, m_addr_o, m_rw_o, m_data_o};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL %s got outputs=%h want 0", nm, v);
        end
    endtask

    task automatic check_strobe_now(input string nm);
        total++;
        if (m_strobe_o !== 1'b1) begin
            bad++;
            $display("FAIL %s got m_strobe_o=%0b want 1", nm, m_strobe_o);
        end
    endtask

    task automatic wait_dones(input int target, input string nm);
        for (int k = 0; k < 300 && done_cnt < target; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt != target) begin
            bad++;
            $display("FAIL %s got dones=%0d want %0d", nm, done_cnt, target);
        end
    endtask

    task automatic pulse(input logic do_i, input logic do_d);
        @(negedge clk);
        i_strobe_i = do_i;
        d_strobe_i = do_d;
        @(negedge clk);
        i_strobe_i = 1'b0;
        d_strobe_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    localparam logic [CLSIZE-1:0] LA5  = {8{32'hA5A5_A5A5}};
    localparam logic [CLSIZE-1:0] LWB  = {8{32'h1234_5678}};
    localparam logic [CLSIZE-1:0] LJNK = {8{32'hDEAD_BEEF}};
    localparam logic [CLSIZE-1:0] L1   = {8{32'h1111_0001}};
    localparam logic [CLSIZE-1:0] L2   = {8{32'h2222_0002}};
    localparam logic [CLSIZE-1:0] L3   = {8{32'h3333_0003}};
    localparam logic [CLSIZE-1:0] L4   = {8{32'h4444_0004}};
    localparam logic [CLSIZE-1:0] L5   = {8{32'h5555_0005}};
    localparam logic [CLSIZE-1:0] L6   = {8{32'h6666_0006}};
    localparam logic [CLSIZE-1:0] L7   = {8{32'h7777_0007}};
    localparam logic [CLSIZE-1:0] L8   = {8{32'h8888_0008}};
    localparam logic [CLSIZE-1:0] L9   = {8{32'h9999_0009}};

    int saved;

    initial begin
        rst_i      = 1'b1;
        i_strobe_i = 1'b0;
        d_strobe_i = 1'b0;
        i_addr_i   = '0;
        d_addr_i   = '0;
        d_rw_i     = 1'b0;
        d_data_i   = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst_i = 1'b0;
        @(negedge clk);
        check_zero("idle_outputs");

        // Lone I read, 5-cycle memory latency
        lat      = 5;
        i_addr_i = 32'h8000_0040;
        exp_req(1'b0, 32'h8000_0040, 1'b0, '0, LA5);
        pulse(1'b1, 1'b0);
        check_strobe_now("i_strobe_latency");
        wait_dones(1, "lone_i_done");

        // D write-back
        lat      = 3;
        d_addr_i = 32'h8000_1000;
        d_rw_i   = 1'b1;
        d_data_i = LWB;
        exp_req(1'b1, 32'h8000_1000, 1'b1, LWB, LJNK);
        pulse(1'b0, 1'b1);
        check_strobe_now("d_strobe_latency");
        wait_dones(2, "d_wb_done");

        // Simultaneous strobes after reset: D wins the first tie
        do_reset();
        lat      = 2;
        i_addr_i = 32'h8000_0200;
        d_addr_i = 32'h8000_0100;
        d_rw_i   = 1'b0;
        d_data_i = LJNK;
        exp_req(1'b1, 32'h8000_0100, 1'b0, '0, L1);
        exp_req(1'b0, 32'h8000_0200, 1'b0, '0, L2);
        pulse(1'b1, 1'b1);
        wait_dones(4, "tie1_done");

        exp_req(1'b1, 32'h8000_0100, 1'b0, '0, L3);
        exp_req(1'b0, 32'h8000_0200, 1'b0, '0, L4);
        pulse(1'b1, 1'b1);
        wait_dones(6, "tie2_done");

        // Lone D write leaves D as last winner
        lat      = 1;
        d_addr_i = 32'h8000_0500;
        d_rw_i   = 1'b1;
        d_data_i = LWB;
        exp_req(1'b1, 32'h8000_0500, 1'b1, LWB, LJNK);
        pulse(1'b0, 1'b1);
        wait_dones(7, "d_wb2_done");

        lat      = 2;
        d_addr_i = 32'h8000_0100;
        d_rw_i   = 1'b0;
`ifdef ARB_DCACHE_PRIORITY_EN
        exp_req(1'b1, 32'h8000_0100, 1'b0, '0, L5);
        exp_req(1'b0, 32'h8000_0200, 1'b0, '0, L6);
`else
        exp_req(1'b0, 32'h8000_0200, 1'b0, '0, L5);
        exp_req(1'b1, 32'h8000_0100, 1'b0, '0, L6);
`endif
        pulse(1'b1, 1'b1);
        wait_dones(9, "tie3_done");

        // One-cycle D strobe while I sits in WAIT
        lat      = 6;
        i_addr_i = 32'h8000_0600;
        d_addr_i = 32'h8000_0700;
        exp_req(1'b0, 32'h8000_0600, 1'b0, '0, L7);
        exp_req(1'b1, 32'h8000_0700, 1'b0, '0, L8);
        pulse(1'b1, 1'b0);
        check_strobe_now("i_strobe_latency2");
        repeat (2) @(negedge clk);
        d_strobe_i = 1'b1;
        @(negedge clk);
        d_strobe_i = 1'b0;
        wait_dones(11, "pulsed_d_done");

        // Reset in WAIT, late m_done_i must be ignored
        lat      = 8;
        i_addr_i = 32'h8000_0300;
        me.addr  = 32'h8000_0300;
        me.rw    = 1'b0;
        me.data  = '0;
        m_q.push_back(me);
        mem_q.push_back(LJNK);
        pulse(1'b1, 1'b0);
        check_strobe_now("i_strobe_latency3");
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check_zero("reset_mid_transfer");
        rst_i = 1'b0;
        saved = done_cnt;
        repeat (12) @(negedge clk);
        total++;
        if (done_cnt != saved) begin
            bad++;
            $display("FAIL no_done_after_reset got dones=%0d want %0d", done_cnt, saved);
        end
        check_zero("idle_after_late_done");

        // Normal request after reset
        lat      = 2;
        d_addr_i = 32'h8000_0400;
        d_rw_i   = 1'b0;
        exp_req(1'b1, 32'h8000_0400, 1'b0, '0, L9);
        pulse(1'b0, 1'b1);
        wait_dones(saved + 1, "post_reset_done");

        // m_done_i coincident with ISSUE
        lat      = 0;
        i_addr_i = 32'h8000_0800;
        exp_req(1'b0, 32'h8000_0800, 1'b0, '0, L2);
        pulse(1'b1, 1'b0);
        wait_dones(saved + 2, "zero_latency_done");

        total++;
        if (m_q.size() != 0 || d_q.size() != 0) begin
            bad++;
            $display("FAIL queues_drained got m_q=%0d d_q=%0d want 0 0", m_q.size(), d_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
